// File: rtl/fcu_pkg.sv
// Shared definitions for the flow control unit: opcodes, condition codes,
// FSM state encoding, instruction field positions and the condition evaluator.
package fcu_pkg;

  // Instruction field layout: [15:12] opcode, [11:8] cond, [7:0] operand
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned COND_LSB = 8;
  localparam int unsigned OPND_LSB = 0;
  localparam int unsigned FIELD_W  = 4;
  localparam int unsigned OPND_W   = 8;

  // Flow opcodes; 0x0-0x7 and 0xC-0xE are non-flow
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BRA  = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Condition codes; 5-15 never hold
  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_Z      = 4'd1;
  localparam logic [3:0] COND_NZ     = 4'd2;
  localparam logic [3:0] COND_C      = 4'd3;
  localparam logic [3:0] COND_NC     = 4'd4;

  // FSM state encoding
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Evaluate a condition field against the ALU flags
  function automatic logic cond_holds(input logic [3:0] cond, input logic z, input logic c);
    case (cond)
      COND_ALWAYS: cond_holds = 1'b1;
      COND_Z:      cond_holds = z;
      COND_NZ:     cond_holds = ~z;
      COND_C:      cond_holds = c;
      COND_NC:     cond_holds = ~c;
      default:     cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fcu_return_stack.sv
// Return-address LIFO, DEPTH entries of WIDTH bits.
// Ports: clk, res (sync active-high), push/pop requests, din (pushed value),
// dout (current top, 0 when empty), full, empty, level (occupied entries).
// A push while full or a pop while empty is ignored.
module fcu_return_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned LW = IW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    cnt;

  // Storage and occupancy; push wins if both are requested
  always_ff @(posedge clk) begin
    if (res) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[IW'(cnt)] <= din;
      cnt           <= cnt + LW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - LW'(1);
    end
  end

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = empty ? '0 : mem[IW'(cnt - LW'(1))];
  assign level = cnt;

endmodule

// File: rtl/flow_control_unit.sv
// Flow control unit: decodes JMP/BRA/CALL/RET/HALT and drives the PC write
// interface combinationally (Mealy); owns the return stack, HALT state and
// post-change flush window.
// Ports: clk, res (sync active-high); instr_valid/instr/instr_pc from fetch;
// flag_z/flag_c from ALU; pc_wr_en/pc_add_offset/pc_target to the PC;
// status flushing, halted, stack_err (sticky), stack_level.
// Optional feature: define FCU_COND_BRANCH_EN to make flow instructions
// conditional on the cond field; otherwise cond and flags are ignored.
module flow_control_unit
  import fcu_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned INSTR_WIDTH  = 16,
  parameter int unsigned STACK_DEPTH  = 4,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          instr_valid,
  input  logic [INSTR_WIDTH-1:0]        instr,
  input  logic [PC_WIDTH-1:0]           instr_pc,
  input  logic                          flag_z,
  input  logic                          flag_c,
  output logic                          pc_wr_en,
  output logic                          pc_add_offset,
  output logic [PC_WIDTH-1:0]           pc_target,
  output logic                          flushing,
  output logic                          halted,
  output logic                          stack_err,
  output logic [$clog2(STACK_DEPTH):0]  stack_level
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [1:0]          state, state_nx;
  logic [FC_W-1:0]     flush_cnt, flush_cnt_nx;
  logic [PC_WIDTH-1:0] halt_addr, halt_addr_nx;
  logic                err_q, err_nx;

  logic [FIELD_W-1:0]  op;
  logic [FIELD_W-1:0]  cond;
  logic [OPND_W-1:0]   operand;
  logic                cond_ok;

  logic                wr_en_c, add_c, taken_c, push_c, pop_c;
  logic [PC_WIDTH-1:0] target_c;

  logic [PC_WIDTH-1:0]          stk_dout;
  logic                         stk_full, stk_empty;
  logic [$clog2(STACK_DEPTH):0] stk_level;

  assign op      = instr[OPC_LSB  +: FIELD_W];
  assign cond    = instr[COND_LSB +: FIELD_W];
  assign operand = instr[OPND_LSB +: OPND_W];

`ifdef FCU_COND_BRANCH_EN
  assign cond_ok = cond_holds(cond, flag_z, flag_c);
`else
  logic unused_cond;
  assign cond_ok     = 1'b1;
  assign unused_cond = ^{cond, flag_z, flag_c};
`endif

  fcu_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_stack (
    .clk   (clk),
    .res   (res),
    .push  (push_c & ~res),
    .pop   (pop_c & ~res),
    .din   (instr_pc + PC_WIDTH'(1)),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty),
    .level (stk_level)
  );

  // State register
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      halt_addr <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
      halt_addr <= halt_addr_nx;
      err_q     <= err_nx;
    end
  end

  // Decode, next state and PC request
  always_comb begin
    state_nx     = state;
    flush_cnt_nx = flush_cnt;
    halt_addr_nx = halt_addr;
    err_nx       = err_q;
    wr_en_c      = 1'b0;
    add_c        = 1'b0;
    target_c     = '0;
    taken_c      = 1'b0;
    push_c       = 1'b0;
    pop_c        = 1'b0;

    case (state)
      ST_RUN: begin
        if (instr_valid) begin
          case (op)
            OP_JMP: if (cond_ok) begin
              taken_c  = 1'b1;
              target_c = PC_WIDTH'(operand);
            end
            OP_BRA: if (cond_ok) begin
              taken_c  = 1'b1;
              add_c    = 1'b1;
              target_c = PC_WIDTH'($signed(operand));
            end
            OP_CALL: if (cond_ok) begin
              if (stk_full) begin
                err_nx = 1'b1;
              end else begin
                taken_c  = 1'b1;
                push_c   = 1'b1;
                target_c = PC_WIDTH'(operand);
              end
            end
            OP_RET: if (cond_ok) begin
              if (stk_empty) begin
                err_nx = 1'b1;
              end else begin
                taken_c  = 1'b1;
                pop_c    = 1'b1;
                target_c = stk_dout;
              end
            end
            OP_HALT: begin
              wr_en_c      = 1'b1;
              target_c     = instr_pc;
              halt_addr_nx = instr_pc;
              state_nx     = ST_HALT;
            end
            default: ;
          endcase
          if (taken_c) begin
            wr_en_c      = 1'b1;
            state_nx     = ST_FLUSH;
            flush_cnt_nx = FC_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) state_nx = ST_RUN;
        else                 flush_cnt_nx = flush_cnt - FC_W'(1);
      end
      ST_HALT: begin
        wr_en_c  = 1'b1;
        target_c = halt_addr;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // Reset forces every output low in the same cycle
  assign pc_wr_en      = wr_en_c & ~res;
  assign pc_add_offset = add_c & ~res;
  assign pc_target     = res ? '0 : target_c;
  assign flushing      = ~res & (state == ST_FLUSH);
  assign halted        = ~res & (state == ST_HALT);
  assign stack_err     = ~res & err_q;
  assign stack_level   = res ? '0 : stk_level;

endmodule

// File: tb/tb_flow_control_unit.sv
// Directed self-checking bench for flow_control_unit (default parameters,
// FLUSH_CYCLES=1, STACK_DEPTH=4). Inputs change on the falling edge and the
// Mealy outputs are sampled 1 time unit later.
module tb_flow_control_unit;
  import fcu_pkg::*;

  logic       clk;
  logic       res;
  logic       instr_valid;
  logic [15:0] instr;
  logic [7:0] instr_pc;
  logic       flag_z;
  logic       flag_c;
  logic       pc_wr_en;
  logic       pc_add_offset;
  logic [7:0] pc_target;
  logic       flushing;
  logic       halted;
  logic       stack_err;
  logic [2:0] stack_level;

  int checks = 0;
  int errors = 0;

  flow_control_unit dut (
    .clk           (clk),
    .res           (res),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .flag_z        (flag_z),
    .flag_c        (flag_c),
    .pc_wr_en      (pc_wr_en),
    .pc_add_offset (pc_add_offset),
    .pc_target     (pc_target),
    .flushing      (flushing),
    .halted        (halted),
    .stack_err     (stack_err),
    .stack_level   (stack_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one instruction slot at the falling edge, then settle
  task automatic cyc(input logic v, input logic [3:0] op, input logic [3:0] cnd,
                     input logic [7:0] opnd, input logic [7:0] pc);
    @(negedge clk);
    instr_valid = v;
    instr       = {op, cnd, opnd};
    instr_pc    = pc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res         = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    res         = 1'b0;
  endtask

  initial begin
    res = 1'b1; instr_valid = 1'b0; instr = '0; instr_pc = '0;
    flag_z = 1'b0; flag_c = 1'b0;

    // Outputs held low during reset even with a valid JMP present
    cyc(1'b1, OP_JMP, 4'd0, 8'h40, 8'h00);
    check("res_wr_en", pc_wr_en, 0);
    check("res_target", pc_target, 0);

    @(negedge clk); res = 1'b0; instr_valid = 1'b0; #1;
    check("idle_wr_en", pc_wr_en, 0);
    check("idle_flushing", flushing, 0);
    check("idle_halted", halted, 0);
    check("idle_level", stack_level, 0);
    check("idle_err", stack_err, 0);

    // JMP then flush window ignores a second JMP
    cyc(1'b1, OP_JMP, 4'd0, 8'h40, 8'h00);
    check("jmp_wr_en", pc_wr_en, 1);
    check("jmp_add", pc_add_offset, 0);
    check("jmp_target", pc_target, 8'h40);
    cyc(1'b1, OP_JMP, 4'd0, 8'h10, 8'h40);
    check("flush_active", flushing, 1);
    check("flush_wr_en", pc_wr_en, 0);
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h41);
    check("flush_done", flushing, 0);

    // BRA negative offset
    cyc(1'b1, OP_BRA, 4'd0, 8'hFE, 8'h01);
    check("bra_wr_en", pc_wr_en, 1);
    check("bra_add", pc_add_offset, 1);
    check("bra_target", pc_target, 8'hFE);
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'hFF);
    check("bra_flush", flushing, 1);

    // Non-flow and reserved opcodes do not touch the PC
    cyc(1'b1, 4'h3, 4'd0, 8'h55, 8'h10);
    check("alu_wr_en", pc_wr_en, 0);
    cyc(1'b1, 4'hD, 4'd0, 8'h55, 8'h11);
    check("rsv_wr_en", pc_wr_en, 0);
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h12);
    check("rsv_noflush", flushing, 0);

    // CALL / RET round trip
    cyc(1'b1, OP_CALL, 4'd0, 8'h20, 8'h05);
    check("call_wr_en", pc_wr_en, 1);
    check("call_target", pc_target, 8'h20);
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h20);
    check("call_level", stack_level, 1);
    cyc(1'b1, OP_RET, 4'd0, 8'h00, 8'h20);
    check("ret_wr_en", pc_wr_en, 1);
    check("ret_add", pc_add_offset, 0);
    check("ret_target", pc_target, 8'h06);
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h06);
    check("ret_level", stack_level, 0);

    // RET on empty stack
    do_reset();
    cyc(1'b1, OP_RET, 4'd0, 8'h00, 8'h10);
    check("uflow_wr_en", pc_wr_en, 0);
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h11);
    check("uflow_err", stack_err, 1);
    check("uflow_noflush", flushing, 0);

    // Overflow on the fifth CALL
    do_reset();
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h00);
    check("rst_err_clr", stack_err, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, OP_CALL, 4'd0, 8'h20, 8'(i));
      check($sformatf("call%0d_wr_en", i), pc_wr_en, (i < 4) ? 1 : 0);
      cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h20);
    end
    check("oflow_err", stack_err, 1);
    check("oflow_level", stack_level, 4);
    check("oflow_noflush", flushing, 0);
    cyc(1'b1, OP_RET, 4'd0, 8'h00, 8'h20);
    check("top_target", pc_target, 8'h04);
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h04);
    check("pop_level", stack_level, 3);

    // HALT freezes the PC until reset
    cyc(1'b1, OP_HALT, 4'd0, 8'h00, 8'h33);
    check("halt_wr_en", pc_wr_en, 1);
    check("halt_target", pc_target, 8'h33);
    check("halt_add", pc_add_offset, 0);
    cyc(1'b1, OP_JMP, 4'd0, 8'h10, 8'h40);
    check("halted", halted, 1);
    check("halted_wr_en", pc_wr_en, 1);
    check("halted_target", pc_target, 8'h33);
    check("halted_noflush", flushing, 0);
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h00);
    check("halted_hold", pc_target, 8'h33);
    @(negedge clk); res = 1'b1; #1;
    check("halt_res_wr_en", pc_wr_en, 0);
    check("halt_res_halted", halted, 0);
    @(negedge clk); res = 1'b0; instr_valid = 1'b0; #1;
    check("post_halted", halted, 0);
    check("post_level", stack_level, 0);
    check("post_err", stack_err, 0);

`ifdef FCU_COND_BRANCH_EN
    flag_z = 1'b0;
    cyc(1'b1, OP_JMP, COND_Z, 8'h40, 8'h00);
    check("cjmp_nt_wr_en", pc_wr_en, 0);
    cyc(1'b0, 4'h0, 4'd0, 8'h00, 8'h01);
    check("cjmp_nt_flush", flushing, 0);
    flag_z = 1'b1;
    cyc(1'b1, OP_JMP, COND_Z, 8'h40, 8'h01);
    check("cjmp_t_wr_en", pc_wr_en, 1);
    check("cjmp_t_target", pc_target, 8'h40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
